// File: rtl/uart_pkg.sv
// Shared UART definitions for the stimulus transmitter.
//   uart_state_t             : transmitter FSM states (PARITY only when
//                              UART_STIM_TX_PARITY_EN is defined)
//   UART_DEFAULT_CLK_PER_BIT : 100 MHz / 115200 baud
//   UART_DATA_BITS           : data bits per frame
//   UART_FRAME_BITS          : bits per frame (start + data [+ parity] + stop)
//   frame_cycles()           : frame length in clock cycles
// Configuration macro: UART_STIM_TX_PARITY_EN (8E1 when defined, else 8N1).
package uart_pkg;

   localparam int UART_DEFAULT_CLK_PER_BIT = 868;
   localparam int UART_DATA_BITS           = 8;

`ifdef UART_STIM_TX_PARITY_EN
   localparam int UART_FRAME_BITS = 11;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
   localparam int UART_FRAME_BITS = 10;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

   function automatic int frame_cycles(input int clk_per_bit);
      return UART_FRAME_BITS * clk_per_bit;
   endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Synchronous byte FIFO feeding the UART stimulus transmitter.
//   clk, reset      : rising-edge clock, async active-high reset
//   push, push_data : write a byte (ignored when full)
//   pop, pop_data   : pop_data shows the head; pop removes it (ignored when empty)
//   full, empty     : status flags
//   level           : number of bytes held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_stim_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  push_data,
   input  logic        push,
   input  logic        pop,
   output logic [7:0]  pop_data,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rptr];

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_stim_tx.sv
// UART stimulus transmitter: buffers bytes and serialises them onto rxd
// (idle high, start bit, 8 data bits LSB first, optional even parity, stop).
//   clk, reset         : rising-edge clock, async active-high reset
//   wr_data, wr_valid  : byte to send, accepted when wr_ready is also high
//   wr_ready           : FIFO has room (low during and just after reset)
//   rxd                : registered serial line toward the receiver under test
//   busy               : frame in progress or bytes still buffered
//   fifo_level         : bytes currently buffered
// Configuration macro: UART_STIM_TX_PARITY_EN adds an even-parity bit.
module uart_stim_tx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   wr_data,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   output logic                         rxd,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int            CW       = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
      $error("uart_stim_tx: CLK_PER_BIT must be at least 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_stim_tx: FIFO_DEPTH must be a power of two, at least 2");
   end

   uart_state_t   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    data_q, data_n;
   logic          rxd_n;
   logic          rdy_q;
   logic          push, pop, full, empty, bit_end;
   logic [7:0]    pop_data;

   // rdy_q keeps wr_ready low until the first edge after reset is released.
   assign wr_ready = rdy_q && !full;
   assign push     = wr_valid && wr_ready;
   assign busy     = (state != IDLE) || !empty;
   assign bit_end  = (cnt == CNT_MAX);

   uart_stim_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_data (wr_data),
      .push      (push),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         data_q  <= '0;
         rxd     <= 1'b1;
         rdy_q   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         data_q  <= data_n;
         rxd     <= rxd_n;
         rdy_q   <= 1'b1;
      end
   end

   // Next state. The baud counter wraps on its own at bit_end, which is
   // exactly when the state or bit index changes.
   always_comb begin
      state_n   = state;
      cnt_n     = bit_end ? '0 : cnt + 1'b1;
      bit_idx_n = bit_idx;
      data_n    = data_q;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               data_n  = pop_data;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_idx_n = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
`ifdef UART_STIM_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_STIM_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
`endif
         STOP: begin
            // Chain straight into the next start bit when more data waits.
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  data_n  = pop_data;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level for the current state; registered so rxd is glitch-free.
   always_comb begin
      rxd_n = 1'b1;
      case (state)
         START:   rxd_n = 1'b0;
         DATA:    rxd_n = data_q[bit_idx];
`ifdef UART_STIM_TX_PARITY_EN
         PARITY:  rxd_n = ^data_q;
`endif
         default: rxd_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx (CLK_PER_BIT=16, FIFO_DEPTH=16). A queue-based
// model predicts rxd/busy/wr_ready/fifo_level every cycle, a line decoder
// reassembles bytes from rxd, and directed scenarios pin exact timings.
// Honors UART_STIM_TX_PARITY_EN for the 8E1 build.
module tb_uart_stim_tx;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
`ifdef UART_STIM_TX_PARITY_EN
   localparam int NB  = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = 10;
   localparam bit PAR = 1'b0;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready, rxd, busy;
   logic [4:0] fifo_level;

   uart_stim_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .rxd        (rxd),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // p = cycles elapsed in the current frame (-1 when no frame); the line
   // shows frame bit p/CPB one cycle after the frame position.
   logic [7:0] q[$];
   logic [7:0] exp_tx[$];
   logic [7:0] cur = 8'h00;
   int         p = -1;
   bit         rdy_en = 1'b0;
   logic       m_rxd = 1'b1;
   bit         m_acc;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PAR && idx == 9) return ^b;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         exp_tx.delete();
         p      = -1;
         rdy_en = 1'b0;
         m_rxd  = 1'b1;
      end else begin
         m_acc = wr_valid && rdy_en && (q.size() < DEPTH);
         m_rxd = (p < 0) ? 1'b1 : frame_bit(cur, p / CPB);
         if (p >= 0) begin
            p++;
            if (p == FRAME) p = -1;
         end
         if (p < 0 && q.size() > 0) begin
            cur = q.pop_front();
            exp_tx.push_back(cur);
            p = 0;
         end
         if (m_acc) q.push_back(wr_data);
         rdy_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      check("rxd", rxd, m_rxd);
      check("wr_ready", wr_ready, rdy_en && q.size() != DEPTH);
      check("busy", busy, (p >= 0) || q.size() != 0);
      check("fifo_level", fifo_level, q.size());
   end

   // ---------------- line decoder ----------------
   int         rx_cnt = -1;
   int         rx_k;
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] rx_log[$];

   always @(negedge clk) begin
      if (reset) begin
         rx_cnt = -1;
      end else if (rx_cnt < 0) begin
         if (rxd === 1'b0) rx_cnt = 0;
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            rx_k = rx_cnt / CPB;
            if (rx_k == 0) check("rx_start", rxd, 1'b0);
            else if (rx_k <= 8) rx_sh[rx_k-1] = rxd;
            else if (PAR && rx_k == 9) check("rx_parity", rxd, ^rx_sh);
            if (rx_k == NB - 1) begin
               check("rx_stop", rxd, 1'b1);
               rx_log.push_back(rx_sh);
               if (exp_tx.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rx_unexpected: got byte %0h expected none", rx_sh);
               end else begin
                  check("rx_byte", rx_sh, exp_tx.pop_front());
               end
               rx_cnt = -1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, busy, 1'b0);
      tick(4);
   endtask

   // Push one byte from idle, then check the line bit by bit at mid-bit,
   // the start-bit latency, and where busy drops.
   task automatic send_frame(input string tag, input logic [7:0] b, input logic [NB-1:0] pat);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      tick(1);
      check({tag, "_pre_start"}, rxd, 1'b1);
      tick(1);
      check({tag, "_start_at_2"}, rxd, 1'b0);
      for (int i = 0; i < NB; i++) begin
         tick(8);
         check({tag, "_bit"}, rxd, pat[i]);
         if (i < NB - 1) tick(8);
      end
      tick(6);
      check({tag, "_busy_end"}, busy, 1'b1);
      tick(1);
      check({tag, "_busy_low"}, busy, 1'b0);
      tick(4);
   endtask

   logic [7:0] burst[20];
   int         max_level;
   bit         saw_not_ready;
   int         busy_low;

   initial begin
      #2 reset = 1'b1;
      tick(3);
      check("rst_rxd", rxd, 1'b1);
      check("rst_level", fifo_level, 5'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", wr_ready, 1'b0);
      #2 reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", wr_ready, 1'b1);
      tick(2);

      // 0x55 single frame
`ifdef UART_STIM_TX_PARITY_EN
      send_frame("x55", 8'h55, 11'b10010101010);
      send_frame("x07", 8'h07, 11'b11000001110);
      send_frame("x03", 8'h03, 11'b10000000110);
`else
      send_frame("x55", 8'h55, 10'b1010101010);
`endif

      // "ABC" back-to-back
      rx_log.delete();
      wr_valid = 1'b1;
      wr_data = 8'h41;
      @(negedge clk);
      wr_data = 8'h42;
      @(negedge clk);
      wr_data = 8'h43;
      @(negedge clk);
      wr_valid = 1'b0;
      busy_low = 0;
      for (int c = 0; c < 3 * FRAME - 1; c++) begin
         if (c == FRAME - 1 || c == 2 * FRAME - 1) check("abc_stop_before_next", rxd, 1'b1);
         if (c == 0 || c == FRAME || c == 2 * FRAME) check("abc_start_no_gap", rxd, 1'b0);
         if (busy !== 1'b1) busy_low++;
         tick(1);
      end
      check("abc_busy_contiguous", busy_low, 0);
      wait_idle("abc", 2 * FRAME);
      check("abc_count", rx_log.size(), 3);
      if (rx_log.size() == 3) begin
         check("abc_A", rx_log[0], 8'h41);
         check("abc_B", rx_log[1], 8'h42);
         check("abc_C", rx_log[2], 8'h43);
      end

      // 20 pushes without waiting: 17 fit (16 buffered + 1 popped at once)
      rx_log.delete();
      for (int i = 0; i < 20; i++) burst[i] = 8'($urandom);
      max_level = 0;
      saw_not_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         wr_data = burst[c];
         wr_valid = 1'b1;
         @(negedge clk);
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (wr_ready === 1'b0) saw_not_ready = 1'b1;
      end
      wr_valid = 1'b0;
      check("burst_max_level", max_level, 16);
      check("burst_ready_dropped", saw_not_ready, 1'b1);
      wait_idle("burst", 20 * FRAME);
      check("burst_count", rx_log.size(), 17);
      for (int i = 0; i < 17; i++)
         if (i < rx_log.size()) check("burst_order", rx_log[i], burst[i]);

      // Push offered on the pop edge while full: refused, level dips to 15
      for (int c = 0; c <= FRAME + 2; c++) begin
         wr_data = 8'($urandom);
         wr_valid = 1'b1;
         @(negedge clk);
         if (c == 16) begin
            check("full_level", fifo_level, 5'd16);
            check("full_not_ready", wr_ready, 1'b0);
         end
         if (c == FRAME) check("pre_pop_level", fifo_level, 5'd16);
         if (c == FRAME + 1) begin
            check("pop_edge_level", fifo_level, 5'd15);
            check("pop_edge_ready", wr_ready, 1'b1);
         end
         if (c == FRAME + 2) begin
            check("refill_level", fifo_level, 5'd16);
            check("refill_not_ready", wr_ready, 1'b0);
         end
      end
      wr_valid = 1'b0;
      wait_idle("full", 20 * FRAME);

      // Reset in the middle of a 0x00 frame
      wr_data = 8'h00;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      tick(52);
      check("mid_frame_low", rxd, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("reset_rxd_now", rxd, 1'b1);
      check("reset_level_now", fifo_level, 5'd0);
      check("reset_busy_now", busy, 1'b0);
      check("reset_ready_now", wr_ready, 1'b0);
      tick(2);
      #2 reset = 1'b0;
      tick(2);
      rx_log.delete();
      wr_data = 8'h5A;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      wait_idle("after_reset", 2 * FRAME);
      check("after_reset_count", rx_log.size(), 1);
      if (rx_log.size() == 1) check("after_reset_5a", rx_log[0], 8'h5A);

      // Random traffic with random gaps
      for (int c = 0; c < 40; c++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data = 8'($urandom);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_idle("random", 45 * FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_stim_tx.md
UART_STIM_TX -- requirements
Module: uart_stim_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte buffer depth; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_data, input, 8 bits: byte to transmit.
REQ-006 SHALL have port wr_valid, input, 1 bit: wr_data is valid this cycle.
REQ-007 SHALL have port wr_ready, output, 1 bit: FIFO can accept a byte.
REQ-008 SHALL have port rxd, output, 1 bit: serial line to the DUT receiver; idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: bytes currently held in the FIFO.

Function
REQ-011 SHALL accept a byte on any rising edge where wr_valid and wr_ready are both 1.
REQ-012 SHALL drive wr_ready = (fifo_level != FIFO_DEPTH); no same-cycle bypass when full.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY and STOP; PARITY exists only when parity is compiled in.
REQ-014 SHALL, in IDLE with FIFO non-empty, pop the head byte and enter START on the next edge.
REQ-015 SHALL drive rxd from a register: 0 in START, data bit in DATA (LSB first), parity bit in PARITY, and 1 in STOP and IDLE.
REQ-016 SHALL hold each bit for exactly CLK_PER_BIT cycles, using a baud counter that counts 0..CLK_PER_BIT-1 and wraps to 0 on every state or bit change.
REQ-017 SHALL advance a 3-bit bit index 0..7 in DATA and leave DATA after index 7 completes.
REQ-018 SHALL make a frame exactly 10*CLK_PER_BIT cycles long, or 11*CLK_PER_BIT with parity.
REQ-019 SHALL, at the end of STOP, go directly to START if the FIFO is non-empty, with zero idle cycles; otherwise it SHALL go to IDLE.
REQ-020 SHALL place the first start bit 2 cycles after the accepting edge when the FIFO was empty and the FSM was IDLE (1 cycle for the FIFO write, 1 cycle for the pop).
REQ-021 SHALL, on a simultaneous push and pop, update the FIFO correctly and leave fifo_level unchanged.
REQ-022 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-023 SHALL assert busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-024 SHALL, while reset is high, asynchronously force: rxd=1, state=IDLE, FIFO empty, fifo_level=0, busy=0, wr_ready=0, and counters=0.
REQ-025 SHALL, on reset mid-frame, abort the frame with rxd high in the same cycle and discard the buffered bytes.
REQ-026 SHALL drive wr_ready=1 on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, when UART_STIM_TX_PARITY_EN is defined, insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP.
REQ-028 SHALL, when UART_STIM_TX_PARITY_EN is undefined, have no PARITY state; STOP follows DATA directly (8N1).

Structure
REQ-029 SHALL take the following from shared package uart_pkg: the state enum typedef, the default baud constant, and the frame-length helper constants.
REQ-030 SHALL instantiate one sub-module, uart_stim_fifo: a synchronous 8-bit FIFO with push, pop, full, empty and level.
REQ-031 SHALL check elaboration-time asserts: CLK_PER_BIT >= 4 and FIFO_DEPTH a power of two.

Verification (CLK_PER_BIT=16, FIFO_DEPTH=16)
REQ-032 SHALL cover: push 0x55 -> rxd = 0,1,0,1,0,1,0,1,0,1 with each bit 16 cycles, frame 160 cycles, busy low after it.
REQ-033 SHALL cover: push 0x41, 0x42, 0x43 back-to-back -> 480 contiguous frame cycles with no idle high between stop and start; rxd looped to uart_model txd prints "ABC".
REQ-034 SHALL cover: 20 pushes without waiting -> fifo_level reaches 16, wr_ready drops, and all accepted bytes are transmitted in order.
REQ-035 SHALL cover: reset at cycle 50 of frame 0x00 -> rxd=1 immediately, fifo_level=0, then a subsequent 0x5A is transmitted cleanly.
REQ-036 SHALL cover, with UART_STIM_TX_PARITY_EN: push 0x07 -> parity bit 1, frame 176 cycles; push 0x03 -> parity bit 0.
REQ-037 SHALL cover: push on the same edge as a pop with level 16 -> push refused, level goes to 15, and wr_ready=1 the next cycle.
